uart_stream_xcvr: RTL and testbench

Parametrised full-duplex UART transceiver with ready/valid byte streams on the core side and serial pads on the pin side. Successor to the fixed-format register-mapped UART: data width, stop bits, bit period and RX buffering are compile-time parameters, and errors are reported per frame. Sits between a tile-level top (pads on uio) and any stream master/slave.

---
 rtl/uart_stream_pkg.sv | 35 +++
 rtl/uart_stream_fifo.sv | 62 ++++++
 rtl/uart_stream_xcvr.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_uart_stream_xcvr.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the uart_stream transceiver family.
// Optional parity support is compiled in with the UART_PARITY_EN macro.
package uart_stream_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    // $clog2 that never returns less than one bit, for counters and pointers.
    function automatic int clog2_min1(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    // Offset of the start-bit midpoint in clock cycles (floor for odd periods).
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 32'sd2;
    endfunction

endpackage

// File: rtl/uart_stream_fifo.sv
// Synchronous FIFO with occupancy counter. A push while full is accepted only
// when a pop happens in the same cycle; rdata shows the head combinationally.
module uart_stream_fifo
    import uart_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage, pointers and level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_stream_xcvr.sv
// Full-duplex UART with ready/valid byte streams on the core side.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD, rx_parity_err_o).
module uart_stream_xcvr
    import uart_stream_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
    ,parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic [DATA_BITS-1:0]             tx_data_i,
    input  logic                             tx_valid_i,
    output logic                             tx_ready_o,
    output logic                             tx_busy_o,
    output logic                             stx_pad_o,
    input  logic                             srx_pad_i,
    output logic [DATA_BITS-1:0]             rx_data_o,
    output logic                             rx_valid_o,
    input  logic                             rx_ready_i,
    output logic                             rx_overrun_o,
    output logic                             rx_frame_err_o,
`ifdef UART_PARITY_EN
    output logic                             rx_parity_err_o,
`endif
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level_o
);

    localparam int CNT_W = clog2_min1(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int IDX_W = clog2_min1(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
    // TX leaves STOP one cycle early so the next start bit follows without a gap.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_r, tx_state_next_s;
    logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_next_s;
    logic [IDX_W-1:0]     tx_idx_r, tx_idx_next_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_next_s;
    logic                 tx_pad_r, tx_pad_next_s;
    logic                 tx_ready_r, tx_busy_r;
`ifdef UART_PARITY_EN
    logic                 tx_par_r;
`endif

    assign stx_pad_o  = tx_pad_r;
    assign tx_ready_o = tx_ready_r;
    assign tx_busy_o  = tx_busy_r;

    // TX next-state logic; the pad value is computed one cycle ahead and registered.
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_cnt_next_s   = tx_cnt_r + 1'b1;
        tx_idx_next_s   = tx_idx_r;
        tx_shift_next_s = tx_shift_r;
        tx_pad_next_s   = tx_pad_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_next_s = '0;
                if (tx_valid_i) begin
                    tx_state_next_s = TX_START;
                    tx_shift_next_s = tx_data_i;
                    tx_pad_next_s   = 1'b0;
                end else begin
                    tx_pad_next_s   = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_next_s = TX_DATA;
                    tx_cnt_next_s   = '0;
                    tx_idx_next_s   = '0;
                    tx_pad_next_s   = tx_shift_r[0];
                end else begin
                    tx_pad_next_s   = 1'b0;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_next_s   = '0;
                    tx_shift_next_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                    if (tx_idx_r == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_next_s = TX_PARITY;
                        tx_pad_next_s   = tx_par_r;
`else
                        tx_state_next_s = TX_STOP;
                        tx_pad_next_s   = 1'b1;
`endif
                    end else begin
                        tx_idx_next_s   = tx_idx_r + 1'b1;
                        tx_pad_next_s   = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_next_s   = tx_cnt_r + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_next_s = TX_STOP;
                    tx_cnt_next_s   = '0;
                    tx_pad_next_s   = 1'b1;
                end else begin
                    tx_cnt_next_s   = tx_cnt_r + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                tx_pad_next_s = 1'b1;
                if (tx_cnt_r == STOP_LAST) begin
                    tx_state_next_s = TX_IDLE;
                    tx_cnt_next_s   = '0;
                end else begin
                    tx_cnt_next_s   = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                tx_state_next_s = TX_IDLE;
                tx_cnt_next_s   = '0;
                tx_pad_next_s   = 1'b1;
            end
        endcase
    end

    // TX state, datapath and registered handshake/pad outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_idx_r   <= '0;
            tx_shift_r <= '0;
            tx_pad_r   <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_busy_r  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_r   <= 1'b0;
`endif
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_cnt_r   <= tx_cnt_next_s;
            tx_idx_r   <= tx_idx_next_s;
            tx_shift_r <= tx_shift_next_s;
            tx_pad_r   <= tx_pad_next_s;
            tx_ready_r <= (tx_state_next_s == TX_IDLE);
            tx_busy_r  <= (tx_state_next_s != TX_IDLE);
`ifdef UART_PARITY_EN
            if (tx_ready_r && tx_valid_i) begin
                tx_par_r <= (^tx_data_i) ^ PARITY_ODD;
            end
`endif
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state_r, rx_state_next_s;
    logic [CNT_W-1:0]     rx_cnt_r, rx_cnt_next_s;
    logic [IDX_W-1:0]     rx_idx_r, rx_idx_next_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_next_s;
    logic                 rx_sync1_r, rx_sync2_r, rx_prev_r;
    logic                 rx_push_s, rx_ferr_s, rx_pop_s, rx_ovr_s;
    logic                 rx_ferr_r, rx_ovr_r;
    logic                 fifo_full_s, fifo_empty_s;
`ifdef UART_PARITY_EN
    logic                 rx_par_bit_r, rx_par_bit_next_s;
    logic                 rx_perr_s, rx_perr_r;
    assign rx_parity_err_o = rx_perr_r;
`endif

    assign rx_frame_err_o = rx_ferr_r;
    assign rx_overrun_o   = rx_ovr_r;
    assign rx_valid_o     = !fifo_empty_s;
    assign rx_pop_s       = rx_ready_i && !fifo_empty_s;
    assign rx_ovr_s       = rx_push_s && fifo_full_s && !rx_pop_s;

    // RX next-state logic: falling edge arms START, bits sampled mid-period.
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_cnt_next_s   = rx_cnt_r + 1'b1;
        rx_idx_next_s   = rx_idx_r;
        rx_shift_next_s = rx_shift_r;
        rx_push_s       = 1'b0;
        rx_ferr_s       = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bit_next_s = rx_par_bit_r;
        rx_perr_s         = 1'b0;
`endif
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_next_s = '0;
                // Needs a high-to-low transition, so a stuck-low line never re-arms.
                if (rx_prev_r && !rx_sync2_r) begin
                    rx_state_next_s = RX_START;
                end else begin
                    rx_state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_next_s = '0;
                    rx_idx_next_s = '0;
                    if (rx_sync2_r) begin
                        rx_state_next_s = RX_IDLE;
                    end else begin
                        rx_state_next_s = RX_DATA;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_next_s   = '0;
                    rx_shift_next_s = {rx_sync2_r, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_idx_r == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_next_s = RX_PARITY;
`else
                        rx_state_next_s = RX_STOP;
`endif
                    end else begin
                        rx_idx_next_s = rx_idx_r + 1'b1;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_next_s     = '0;
                    rx_par_bit_next_s = rx_sync2_r;
                    rx_state_next_s   = RX_STOP;
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_next_s   = '0;
                    rx_state_next_s = RX_IDLE;
                    if (!rx_sync2_r) begin
                        rx_ferr_s = 1'b1;
`ifdef UART_PARITY_EN
                    end else if (((^rx_shift_r) ^ rx_par_bit_r) != PARITY_ODD) begin
                        rx_perr_s = 1'b1;
`endif
                    end else begin
                        rx_push_s = 1'b1;
                    end
                end else begin
                    rx_cnt_next_s = rx_cnt_r + 1'b1;
                end
            end
            default: begin
                rx_state_next_s = RX_IDLE;
                rx_cnt_next_s   = '0;
            end
        endcase
    end

    // RX synchronizer, FSM state and registered error pulses.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_idx_r   <= '0;
            rx_shift_r <= '0;
            rx_ferr_r  <= 1'b0;
            rx_ovr_r   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit_r <= 1'b0;
            rx_perr_r    <= 1'b0;
`endif
        end else begin
            rx_sync1_r <= srx_pad_i;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
            rx_state_r <= rx_state_next_s;
            rx_cnt_r   <= rx_cnt_next_s;
            rx_idx_r   <= rx_idx_next_s;
            rx_shift_r <= rx_shift_next_s;
            rx_ferr_r  <= rx_ferr_s;
            rx_ovr_r   <= rx_ovr_s;
`ifdef UART_PARITY_EN
            rx_par_bit_r <= rx_par_bit_next_s;
            rx_perr_r    <= rx_perr_s;
`endif
        end
    end

    uart_stream_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .wdata (rx_shift_r),
        .rdata (rx_data_o),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (rx_level_o)
    );

endmodule

// File: tb/tb_uart_stream_xcvr.sv
// Directed bench for uart_stream_xcvr with a byte scoreboard on the RX stream.
// Builds with or without UART_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_stream_xcvr;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam bit PODD       = 1'b0;
    localparam int FRAME_BITS = 1 + DB + 1 + SB;
`else
    localparam int FRAME_BITS = 1 + DB + SB;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [DB-1:0]           tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    tx_busy;
    logic                    stx;
    logic                    srx;
    logic                    srx_drv;
    logic                    loop_en;
    logic [DB-1:0]           rx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic                    rx_overrun;
    logic                    rx_frame_err;
    logic [$clog2(DEPTH):0]  rx_level;
`ifdef UART_PARITY_EN
    logic                    rx_parity_err;
    logic                    par_flip = 1'b0;
    int                      perr_cnt = 0;
`endif

    int checks   = 0;
    int errors   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [DB-1:0] exp_q[$];

    assign srx = loop_en ? stx : srx_drv;

    always #5 clk = ~clk;

    uart_stream_xcvr #(
        .CLKS_PER_BIT  (CPB),
        .DATA_BITS     (DB),
        .STOP_BITS     (SB),
        .RX_FIFO_DEPTH (DEPTH)
`ifdef UART_PARITY_EN
        ,.PARITY_ODD   (PODD)
`endif
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .tx_busy_o      (tx_busy),
        .stx_pad_o      (stx),
        .srx_pad_i      (srx),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready),
        .rx_overrun_o   (rx_overrun),
        .rx_frame_err_o (rx_frame_err),
`ifdef UART_PARITY_EN
        .rx_parity_err_o(rx_parity_err),
`endif
        .rx_level_o     (rx_level)
    );

    // Count error pulses on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
            if (rx_overrun)   ovr_cnt  <= ovr_cnt + 1;
`ifdef UART_PARITY_EN
            if (rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one serial frame on srx; bad_stop pulls the first stop bit low.
    task automatic send_frame(input logic [DB-1:0] d, input logic bad_stop);
        srx_drv = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < DB; i++) begin
            srx_drv = d[i];
            repeat (CPB) tick();
        end
`ifdef UART_PARITY_EN
        srx_drv = (^d) ^ PODD ^ par_flip;
        repeat (CPB) tick();
`endif
        srx_drv = !bad_stop;
        repeat (CPB) tick();
        srx_drv = 1'b1;
        repeat ((SB - 1) * CPB + 2 * CPB) tick();
    endtask

    // Offer a byte on the TX stream and wait (bounded) for the handshake.
    task automatic send_tx(input logic [DB-1:0] b);
        int k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(b);
        while (!tx_ready && k < 400) begin
            tick();
            k++;
        end
        check("tx_accept", {31'd0, tx_ready}, 32'd1);
        tick();
    endtask

    task automatic wait_level(input int n, input int bound, input string tag);
        int k = 0;
        while (rx_level != n && k < bound) begin
            tick();
            k++;
        end
        check(tag, rx_level, n);
    endtask

    task automatic pop_check(input string tag);
        logic [DB-1:0] e;
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        check({tag, "_data"}, rx_data, e);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int f0, o0;
        logic [FRAME_BITS-1:0] fr;

        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; srx_drv = 1'b1; loop_en = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_stx", {31'd0, stx}, 32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_rx_level", rx_level, 32'd0);
        check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // TX 0xA5: every cycle of the frame on the pad, ready back after one frame.
`ifdef UART_PARITY_EN
        fr = {{SB{1'b1}}, (^8'hA5) ^ PODD, 8'hA5, 1'b0};
`else
        fr = {{SB{1'b1}}, 8'hA5, 1'b0};
`endif
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 1; k <= FRAME_BITS * CPB; k++) begin
            check("tx_pad", {31'd0, stx}, {31'd0, fr[(k - 1) / CPB]});
            check("tx_ready_time", {31'd0, tx_ready}, {31'd0, k == FRAME_BITS * CPB});
            check("tx_busy_time", {31'd0, tx_busy}, {31'd0, k != FRAME_BITS * CPB});
            tick();
        end

        // Loopback, back-to-back with tx_valid held.
        loop_en = 1'b1;
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h5A);
        tx_valid = 1'b0;
        wait_level(3, 4 * FRAME_BITS * CPB, "loop_level");
        pop_check("loop0");
        pop_check("loop1");
        pop_check("loop2");
        check("loop_ferr", ferr_cnt, f0);
        check("loop_ovr", ovr_cnt, o0);
        repeat (2 * CPB) tick();
        loop_en = 1'b0;

        // Short glitch must not produce a frame; a following frame still lands.
        srx_drv = 1'b0;
        repeat (5) tick();
        srx_drv = 1'b1;
        repeat (3 * CPB) tick();
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        check("glitch_level", rx_level, 32'd0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0);
        wait_level(1, 4 * CPB, "post_glitch_level");
        pop_check("post_glitch");

        // Stop bit low: one frame error, nothing stored, next frame fine.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1);
        check("ferr_pulse_once", ferr_cnt, f0 + 1);
        check("ferr_level", rx_level, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0);
        wait_level(1, 4 * CPB, "ferr_recover_level");
        pop_check("ferr_recover");

        // Five frames with no consumer: four kept, the fifth dropped.
        o0 = ovr_cnt;
        for (int i = 0; i < 5; i++) begin
            logic [DB-1:0] d;
            d = DB'(8'h11 * (i + 1));
            if (i < 4) exp_q.push_back(d);
            send_frame(d, 1'b0);
        end
        check("ovr_level", rx_level, 32'd4);
        check("ovr_pulse_once", ovr_cnt, o0 + 1);
        for (int i = 0; i < 4; i++) pop_check("ovr_pop");
        check("ovr_drained", {31'd0, rx_valid}, 32'd0);

        // Reset in the middle of TX data bit 3 with RX mid-frame via loopback.
        loop_en = 1'b1;
        tx_data = 8'h55; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (4 * CPB + CPB / 2 - 1) tick();
        check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stx", {31'd0, stx}, 32'd1);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        f0 = ferr_cnt;
        repeat (2 * FRAME_BITS * CPB) tick();
        check("post_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("post_rst_level", rx_level, 32'd0);
        check("post_rst_ferr", ferr_cnt, f0);
        check("post_rst_stx", {31'd0, stx}, 32'd1);
        loop_en = 1'b0;

`ifdef UART_PARITY_EN
        // 0x01 carrying parity bit 0 under even parity.
        begin
            int p0;
            p0 = perr_cnt;
            par_flip = 1'b1;
            send_frame(8'h01, 1'b0);
            par_flip = 1'b0;
            check("perr_pulse", perr_cnt, p0 + 1);
            check("perr_level", rx_level, 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
